omsp_wdt_timer: RTL and testbench
=================================

// Module: omsp_wdt_timer
// PURPOSE
//  Watchdog/interval timer on the peripheral bus, directly upstream of the clock module: it counts
//  smclk_en or aclk_en ticks and drives wdt_reset, which the clock module turns into a PUC.
//  In interval mode it raises an interrupt flag instead of a reset. One register: WDTCTL, word 0x0120.
// PARAMETERS
//  WDTCTL_ADDR  9'h120  byte address of WDTCTL (per_addr decode = WDTCTL_ADDR/2 = 8'h90)
//  WDT_PW       8'h5A   write password, checked in per_din[15:8]
//  WDT_RDPW     8'h69   value returned in per_dout[15:8] on read
// PORTS
//  mclk         in   1   main system clock
//  por_reset_a  in   1   asynchronous reset, active-high
//  per_addr     in   8   peripheral word address
//  per_din      in  16   peripheral write data
//  per_en       in   1   peripheral enable
//  per_we       in   2   byte write enables {hi,lo}
//  smclk_en     in   1   SMCLK tick, one mclk cycle wide
//  aclk_en      in   1   ACLK tick, one mclk cycle wide
//  wdtie        in   1   interval interrupt enable (IE1 bit)
//  wdt_irq_acc  in   1   interrupt acknowledge, clears wdtifg
//  per_dout     out 16   read data, 0 when not addressed
//  wdt_irq      out  1   interval interrupt request
//  wdt_reset    out  1   watchdog reset request to clock module (one-cycle pulse)
//  wdtifg       out  1   watchdog interrupt flag
// BEHAVIOUR
//  Reset: por_reset_a asynchronously clears ctrl[7:0], cnt[15:0], wdtifg, wdt_reset; all outputs 0.
//  WDTCTL low byte: [7]HOLD [4]TMSEL [3]CNTCL [2]SSEL [1:0]IS; bits 6,5 read 0. CNTCL is write-only
//   and always reads 0.
//  Read: per_en & per_we==0 & addr hit -> per_dout={WDT_RDPW, ctrl & 8'h97} same cycle (combinational).
//  Write: only a word write (per_we==2'b11) with per_din[15:8]==WDT_PW updates ctrl next edge.
//   - Any other write hitting WDTCTL is a violation: ctrl unchanged, wdt_reset=1 next cycle.
//  Tick = SSEL ? aclk_en : smclk_en; counting happens when tick & ~HOLD.
//  Tap: IS=00 -> 32768, 01 -> 8192, 10 -> 512, 11 -> 64 ticks.
//  Expire = counting tick while cnt == tap-1; cnt wraps to 0 on that tick.
//  Counter is 16 bits; the comparison uses only the tap bits, with all lower bits ones.
//  Clear priority: valid write with CNTCL=1 forces cnt=0 that edge, overriding a same-cycle tick.
//  HOLD=1 freezes cnt; expiry impossible.
//  Watchdog mode (TMSEL=0), expire -> wdt_reset=1 for exactly one cycle (registered, 1 cycle after
//   the expiring tick).
//  Reset-event cycle (wdt_reset=1 from expiry or violation): at the same edge ctrl<=0 and cnt<=0,
//   and wdtifg<=1 to record the watchdog as the reset source. Module is not reset by PUC.
//  Interval mode (TMSEL=1), expire -> wdtifg<=1 next edge; no reset.
//  wdtifg clears on wdt_irq_acc or on a valid write of 0 (n/a: flag is not in WDTCTL; acc only).
//   If set and acc coincide, set wins.
//  wdt_irq = wdtifg & wdtie & TMSEL (combinational).
//  A violation and an expiry in the same cycle produce a single one-cycle wdt_reset.
//  A por_reset_a assertion mid-count aborts immediately; after release, the block restarts in
//   watchdog mode, SMCLK, 32768.
// TESTING
//  1. After por, send 32768 smclk_en ticks with no writes -> wdt_reset pulses 1 cycle after tick
//     32768; cnt=0, ctrl=0, wdtifg=1.
//  2. Write 16'h5A1B (TMSEL, CNTCL, IS=11), send 64 ticks -> wdtifg=1, no wdt_reset.
//     With wdtie=1 -> wdt_irq=1; pulse wdt_irq_acc -> wdtifg=0.
//  3. Write 16'h1234 to 0x0120 -> wdt_reset pulse next cycle, ctrl stays 0. Byte write
//     per_we=2'b01 gives the same result.
//  4. Write 16'h5A80 (HOLD), then 100000 ticks -> cnt frozen, no reset. Read returns 16'h6980.
//  5. Write 16'h5A0C (CNTCL, SSEL=ACLK) on the same cycle as an aclk_en tick -> cnt=0.
//     smclk_en ticks are ignored; reset occurs after 32768 aclk ticks.
//  6. Assert por_reset_a at cnt=1000 in interval mode -> all outputs 0 immediately.
//     Read after release = 16'h6900.

Source files
------------

// File: rtl/omsp_wdt_timer.sv
// Watchdog / interval timer with the single password-protected WDTCTL register.
// Counts SMCLK or ACLK ticks and requests a PUC (wdt_reset) or sets wdtifg on expiry.
module omsp_wdt_timer #(
  parameter logic [8:0] WDTCTL_ADDR = 9'h120,
  parameter logic [7:0] WDT_PW      = 8'h5A,
  parameter logic [7:0] WDT_RDPW    = 8'h69
) (
  input  logic        mclk,
  input  logic        por_reset_a,
  input  logic [7:0]  per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        smclk_en,
  input  logic        aclk_en,
  input  logic        wdtie,
  input  logic        wdt_irq_acc,
  output logic [15:0] per_dout,
  output logic        wdt_irq,
  output logic        wdt_reset,
  output logic        wdtifg
);

  localparam logic [7:0] REG_ADDR  = WDTCTL_ADDR[8:1];
  // Only HOLD, TMSEL, SSEL and IS are stored; CNTCL and bits 6:5 never reach the register.
  localparam logic [7:0] CTRL_MASK = 8'h97;

  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wdt_reset_q, wdt_reset_d;
  logic        wdtifg_q, wdtifg_d;

  logic        reg_hit, reg_rd, reg_wr, wr_valid, wr_viol;
  logic        hold, tmsel, ssel;
  logic        tick, count_en, expire, rst_event;
  logic [15:0] tap_mask;

  assign hold  = ctrl_q[7];
  assign tmsel = ctrl_q[4];
  assign ssel  = ctrl_q[2];

  assign reg_hit  = per_en & (per_addr == REG_ADDR);
  assign reg_rd   = reg_hit & (per_we == 2'b00);
  assign reg_wr   = reg_hit & (per_we != 2'b00);
  assign wr_valid = reg_wr & (per_we == 2'b11) & (per_din[15:8] == WDT_PW);
  assign wr_viol  = reg_wr & ~wr_valid;

  assign tick     = ssel ? aclk_en : smclk_en;
  assign count_en = tick & ~hold;

  always_comb begin
    tap_mask = 16'h7FFF;
    case (ctrl_q[1:0])
      2'b00: tap_mask = 16'h7FFF;
      2'b01: tap_mask = 16'h1FFF;
      2'b10: tap_mask = 16'h01FF;
      2'b11: tap_mask = 16'h003F;
      default: tap_mask = 16'h7FFF;
    endcase
  end

  // Only the tap bits take part in the compare, so a shortened interval still fires.
  assign expire    = count_en & ((cnt_q & tap_mask) == tap_mask);
  assign rst_event = wr_viol | (expire & ~tmsel);

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_valid) ctrl_d = per_din[7:0] & CTRL_MASK;
    if (rst_event) ctrl_d = '0;

    cnt_d = cnt_q;
    if (count_en) cnt_d = expire ? '0 : cnt_q + 16'd1;
    if (wr_valid && per_din[3]) cnt_d = '0;
    if (rst_event) cnt_d = '0;

    wdt_reset_d = rst_event;

    wdtifg_d = wdtifg_q;
    if (wdt_irq_acc) wdtifg_d = 1'b0;
    if ((expire & tmsel) | rst_event) wdtifg_d = 1'b1;
  end

  always_ff @(posedge mclk or posedge por_reset_a) begin
    if (por_reset_a) begin
      ctrl_q      <= '0;
      cnt_q       <= '0;
      wdt_reset_q <= 1'b0;
      wdtifg_q    <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      cnt_q       <= cnt_d;
      wdt_reset_q <= wdt_reset_d;
      wdtifg_q    <= wdtifg_d;
    end
  end

  assign per_dout  = reg_rd ? {WDT_RDPW, ctrl_q} : '0;
  assign wdt_reset = wdt_reset_q;
  assign wdtifg    = wdtifg_q;
  assign wdt_irq   = wdtifg_q & wdtie & tmsel;

endmodule

// File: tb/tb_omsp_wdt_timer.sv
// Self-checking bench for omsp_wdt_timer against a tick-count reference model.
module tb_omsp_wdt_timer;

  logic        mclk = 1'b0;
  logic        por_reset_a = 1'b1;
  logic [7:0]  per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic        smclk_en = 1'b0;
  logic        aclk_en = 1'b0;
  logic        wdtie = 1'b0;
  logic        wdt_irq_acc = 1'b0;
  logic [15:0] per_dout;
  logic        wdt_irq, wdt_reset, wdtifg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_ctrl;
  int unsigned m_cnt;
  logic        m_ifg, m_rst;
  logic [15:0] m_dout, dout_pre;

  omsp_wdt_timer #(.WDTCTL_ADDR(9'h120), .WDT_PW(8'h5A), .WDT_RDPW(8'h69)) dut (
    .mclk(mclk), .por_reset_a(por_reset_a), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .smclk_en(smclk_en), .aclk_en(aclk_en),
    .wdtie(wdtie), .wdt_irq_acc(wdt_irq_acc), .per_dout(per_dout), .wdt_irq(wdt_irq),
    .wdt_reset(wdt_reset), .wdtifg(wdtifg)
  );

  always #5 mclk = ~mclk;

  function automatic int unsigned tap_of(input logic [1:0] is);
    case (is)
      2'b00: return 32768;
      2'b01: return 8192;
      2'b10: return 512;
      default: return 64;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h00; m_cnt = 0; m_ifg = 1'b0; m_rst = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] a, input logic [15:0] d, input logic en,
                            input logic [1:0] we, input logic sm, input logic ac, input logic acc);
    bit wr, valid, viol, tk, ex, rst;
    int unsigned tap;
    wr    = en && (a == 8'h90) && (we != 2'b00);
    valid = wr && (we == 2'b11) && (d[15:8] == 8'h5A);
    viol  = wr && !valid;
    tk    = (m_ctrl[2] ? ac : sm) && !m_ctrl[7];
    tap   = tap_of(m_ctrl[1:0]);
    ex    = tk && ((m_cnt % tap) == tap - 1);
    rst   = viol || (ex && !m_ctrl[4]);
    if (acc) m_ifg = 1'b0;
    if ((ex && m_ctrl[4]) || rst) m_ifg = 1'b1;
    if (valid && d[3]) m_cnt = 0;
    else if (ex) m_cnt = 0;
    else if (tk) m_cnt = (m_cnt + 1) % 65536;
    if (valid) m_ctrl = d[7:0] & 8'h97;
    if (rst) begin m_ctrl = 8'h00; m_cnt = 0; end
    m_rst = rst;
  endtask

  // One mclk cycle: drive inputs, capture the combinational read, advance DUT and model.
  task automatic cyc(input logic [7:0] a, input logic [15:0] d, input logic en,
                     input logic [1:0] we, input logic sm, input logic ac, input logic acc);
    per_addr = a; per_din = d; per_en = en; per_we = we;
    smclk_en = sm; aclk_en = ac; wdt_irq_acc = acc;
    #1;
    m_dout   = (en && we == 2'b00 && a == 8'h90) ? {8'h69, m_ctrl} : 16'h0000;
    dout_pre = per_dout;
    @(posedge mclk);
    model_step(a, d, en, we, sm, ac, acc);
    #1;
  endtask

  task automatic idle();
    cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [15:0] d);
    cyc(8'h90, d, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(8'h90, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    if ({wdt_reset, wdtifg, wdt_irq, per_dout} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs got rst=%b ifg=%b irq=%b dout=%h want all 0",
                         wdt_reset, wdtifg, wdt_irq, per_dout);
    end
    checks++;
    @(negedge mclk); #2 por_reset_a = 1'b0;
    @(posedge mclk); #1;
    model_reset();
    rd();
    if (dout_pre !== 16'h6900) begin
      errors++; $display("FAIL reset_read got %h want 6900", dout_pre);
    end
    checks++;
  endtask

  task automatic test_watchdog_expiry();
    for (int i = 1; i <= 32768; i++) begin
      cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      if (wdt_reset !== m_rst || wdtifg !== m_ifg) begin
        errors++; $display("FAIL wd_tick%0d rst=%b want %b ifg=%b want %b",
                           i, wdt_reset, m_rst, wdtifg, m_ifg);
      end
      checks++;
    end
    if (wdt_reset !== 1'b1 || wdtifg !== 1'b1) begin
      errors++; $display("FAIL wd_expire rst=%b ifg=%b want 1 1", wdt_reset, wdtifg);
    end
    checks++;
    idle();
    rd();
    if (wdt_reset !== 1'b0 || dout_pre !== 16'h6900) begin
      errors++; $display("FAIL wd_after rst=%b dout=%h want 0 6900", wdt_reset, dout_pre);
    end
    checks++;
  endtask

  task automatic test_interval();
    cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    if (wdtifg !== 1'b0) begin
      errors++; $display("FAIL int_acc_pre ifg=%b want 0", wdtifg);
    end
    checks++;
    wdtie = 1'b1;
    wr(16'h5A1B);
    for (int i = 1; i <= 64; i++) begin
      cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      if (wdt_reset !== m_rst || wdtifg !== m_ifg || wdt_irq !== (m_ifg & wdtie & m_ctrl[4])) begin
        errors++; $display("FAIL int_tick%0d rst=%b/%b ifg=%b/%b irq=%b",
                           i, wdt_reset, m_rst, wdtifg, m_ifg, wdt_irq);
      end
      checks++;
    end
    if (wdtifg !== 1'b1 || wdt_irq !== 1'b1 || wdt_reset !== 1'b0) begin
      errors++; $display("FAIL int_expire ifg=%b irq=%b rst=%b want 1 1 0", wdtifg, wdt_irq, wdt_reset);
    end
    checks++;
    cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    if (wdtifg !== 1'b0 || wdt_irq !== 1'b0) begin
      errors++; $display("FAIL int_ack ifg=%b irq=%b want 0 0", wdtifg, wdt_irq);
    end
    checks++;
  endtask

  task automatic test_violation();
    cyc(8'h90, 16'h1234, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    if (wdt_reset !== 1'b1) begin
      errors++; $display("FAIL viol_word rst=%b want 1", wdt_reset);
    end
    checks++;
    rd();
    if (wdt_reset !== 1'b0 || dout_pre !== 16'h6900) begin
      errors++; $display("FAIL viol_after rst=%b dout=%h want 0 6900", wdt_reset, dout_pre);
    end
    checks++;
    cyc(8'h90, 16'h5A13, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    if (wdt_reset !== 1'b1) begin
      errors++; $display("FAIL viol_byte rst=%b want 1", wdt_reset);
    end
    checks++;
    rd();
    if (wdt_reset !== 1'b0 || dout_pre !== 16'h6900) begin
      errors++; $display("FAIL viol_byte_after rst=%b dout=%h want 0 6900", wdt_reset, dout_pre);
    end
    checks++;
  endtask

  task automatic test_hold();
    wr(16'h5A80);
    for (int i = 0; i < 1000; i++) cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    rd();
    if (dout_pre !== 16'h6980 || wdt_reset !== 1'b0) begin
      errors++; $display("FAIL hold_read dout=%h rst=%b want 6980 0", dout_pre, wdt_reset);
    end
    checks++;
    wr(16'h5A83);
    for (int i = 0; i < 1000; i++) begin
      cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      if (wdt_reset !== 1'b0) begin
        errors++; $display("FAIL hold_tick%0d rst=%b want 0", i, wdt_reset);
      end
      checks++;
    end
    // Releasing HOLD: the counter must resume from where it was frozen.
    wr(16'h5A03);
    for (int i = 1; i <= 70; i++) begin
      cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      if (wdt_reset !== m_rst || wdtifg !== m_ifg) begin
        errors++; $display("FAIL hold_release%0d rst=%b/%b ifg=%b/%b", i, wdt_reset, m_rst, wdtifg, m_ifg);
      end
      checks++;
    end
  endtask

  task automatic test_clear_aclk();
    int aticks;
    wr(16'h5A04);
    for (int i = 0; i < 10; i++) cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc(8'h90, 16'h5A0F, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
    aticks = 0;
    for (int i = 0; i < 400 && aticks < 64; i++) begin
      logic ac;
      ac = ($urandom_range(0, 2) == 0);
      cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, ac, 1'b0);
      if (ac) aticks++;
      if (wdt_reset !== m_rst || wdt_reset !== (aticks == 64)) begin
        errors++; $display("FAIL aclk_cycle%0d rst=%b model=%b aticks=%0d", i, wdt_reset, m_rst, aticks);
      end
      checks++;
    end
    if (aticks != 64) begin
      errors++; $display("FAIL aclk_budget aticks=%0d want 64", aticks);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] a; logic [15:0] d; logic en; logic [1:0] we;
      r = $urandom_range(0, 99);
      a = 8'h00; d = 16'h0000; en = 1'b0; we = 2'b00;
      if (i % 100 == 0) wdtie = $urandom_range(0, 1);
      if (r < 5) begin
        d = {8'h5A, 8'($urandom)};
        if ($urandom_range(0, 3) != 0) d[1:0] = 2'b11;
        if ($urandom_range(0, 3) != 0) d[7] = 1'b0;
        a = 8'h90; en = 1'b1; we = 2'b11;
      end else if (r < 7) begin
        d = 16'($urandom); we = 2'($urandom_range(1, 3));
        if (we == 2'b11 && d[15:8] == 8'h5A) d[15:8] = 8'h5B;
        a = 8'h90; en = 1'b1;
      end else if (r < 15) begin
        a = 8'h90; en = 1'b1;
      end else if (r < 20) begin
        a = 8'($urandom); if (a == 8'h90) a = 8'h91;
        d = 16'($urandom); en = 1'b1; we = 2'($urandom);
      end
      cyc(a, d, en, we, 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
      if (dout_pre !== m_dout || wdt_reset !== m_rst || wdtifg !== m_ifg ||
          wdt_irq !== (m_ifg & wdtie & m_ctrl[4])) begin
        errors++; $display("FAIL rand%0d dout=%h/%h rst=%b/%b ifg=%b/%b irq=%b",
                           i, dout_pre, m_dout, wdt_reset, m_rst, wdtifg, m_ifg, wdt_irq);
      end
      checks++;
    end
  endtask

  task automatic test_por_midcount();
    wdtie = 1'b1;
    wr(16'h5A13);
    for (int i = 0; i < 64; i++) cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    wr(16'h5A18);
    for (int i = 0; i < 1000; i++) cyc(8'h00, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    if (wdt_irq !== 1'b1) begin
      errors++; $display("FAIL por_pre irq=%b want 1", wdt_irq);
    end
    checks++;
    #2 por_reset_a = 1'b1;
    #1;
    if ({wdt_reset, wdtifg, wdt_irq, per_dout} !== 19'd0) begin
      errors++; $display("FAIL por_async rst=%b ifg=%b irq=%b dout=%h want all 0",
                         wdt_reset, wdtifg, wdt_irq, per_dout);
    end
    checks++;
    @(negedge mclk); #2 por_reset_a = 1'b0;
    @(posedge mclk); #1;
    model_reset();
    rd();
    if (dout_pre !== 16'h6900) begin
      errors++; $display("FAIL por_read got %h want 6900", dout_pre);
    end
    checks++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_watchdog_expiry();
    test_interval();
    test_violation();
    test_hold();
    test_clear_aclk();
    test_random();
    test_por_midcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
